// File: rtl/fetch_pkg.sv
// Shared constants and entry layout for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned PC_ALIGN_BITS = 2;
    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

    localparam int unsigned ENTRY_PC_W    = 64;
    localparam int unsigned ENTRY_INSTR_W = 32;

    // Queue entry layout; the queue stores it flattened as {pc, instr}.
    typedef struct packed {
        logic [ENTRY_PC_W-1:0]    pc;
        logic [ENTRY_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO with flush; head entry is presented from storage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ENTRY_W = 96
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          push,
    input  logic [ENTRY_W-1:0]            push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          head_valid,
    output logic [ENTRY_W-1:0]            head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_ptr_q];

    // The issue credit reserves a slot for every read, so a push never meets a full queue.
    a_no_overflow: assert property (@(posedge clk) disable iff (arst)
        !(push && !flush && (count_q == CNT_W'(DEPTH))))
        else $error("fetch_queue: push into full queue");

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, one-deep in-flight tracker, credit-gated
// sequential issue into a prefetch queue, and redirect with flush/kill.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               enable,
    output logic [DATA_W-1:0]  imem_addr,
    output logic               imem_ren,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [DATA_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [DATA_W-1:0]  out_pc
);

    localparam int unsigned ENTRY_W = DATA_W + INSTR_W;
    localparam int unsigned CNT_W   = cnt_width(DEPTH);
    localparam logic [DATA_W-1:0] ALIGN_MASK =
        DATA_W'((64'd1 << PC_ALIGN_BITS) - 64'd1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_unit: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [DATA_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;

    logic [CNT_W-1:0]   q_count;
    logic               q_valid;
    logic [ENTRY_W-1:0] q_head;
    logic [CNT_W:0]     occupancy;
    logic               issue;
    logic               push;
    logic               pop;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;

        // Pop credit is deliberately ignored: a slot is held for every read in flight.
        occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
        issue     = !arst && enable && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
        push      = inflight_q && !redirect;
        pop       = q_valid && out_ready && !redirect;

        if (redirect) begin
            fetch_pc_d = redirect_pc & ~ALIGN_MASK;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + DATA_W'(PC_STEP);
            inflight_pc_d = fetch_pc_q;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_queue (
        .clk        (clk),
        .arst       (arst),
        .push       (push),
        .push_data  ({inflight_pc_q, imem_rdata}),
        .pop        (pop),
        .flush      (redirect),
        .count      (q_count),
        .head_valid (q_valid),
        .head_data  (q_head)
    );

    assign imem_ren  = issue;
    assign imem_addr = fetch_pc_q;
    assign out_valid = q_valid;
    assign out_pc    = q_head[ENTRY_W-1:INSTR_W];
    assign out_instr = q_head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with an addr/4 instruction memory.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        arst;
    logic        enable;
    logic [63:0] imem_addr;
    logic        imem_ren;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(
        .DATA_W   (64),
        .INSTR_W  (32),
        .DEPTH    (4),
        .RESET_PC (64'h0)
    ) dut (
        .clk         (clk),
        .arst        (arst),
        .enable      (enable),
        .imem_addr   (imem_addr),
        .imem_ren    (imem_ren),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns the word index of the address one cycle after the request.
    initial imem_rdata = 32'h0;
    always @(posedge clk) begin
        if (imem_ren) imem_rdata <= imem_addr[33:2];
    end

    typedef struct {
        logic         en;
        logic         rdy;
        logic         redir;
        logic [63:0]  rpc;
        logic         exp_ren;
        logic [63:0]  exp_addr;
        logic         exp_vld;
        fetch_entry_t exp_head;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic rdy, input logic redir,
                                input logic [63:0] rpc, input logic ren,
                                input logic [63:0] addr, input logic vld,
                                input logic [63:0] pc, input logic [31:0] instr);
        vec_t v;
        v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.exp_ren = ren; v.exp_addr = addr; v.exp_vld = vld;
        v.exp_head.pc = pc; v.exp_head.instr = instr;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got 0x%0h expected 0x%0h", name, idx, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst_valid", idx, 64'(out_valid), 64'h0);
        check("rst_instr", idx, 64'(out_instr), 64'h0);
        check("rst_pc",    idx, out_pc,         64'h0);
        check("rst_ren",   idx, 64'(imem_ren),  64'h0);
        check("rst_addr",  idx, imem_addr,      64'h0);
    endtask

    localparam logic [63:0] TOP4 = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        int ren_cnt;

        arst = 1'b1; enable = 1'b0; out_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 64'h0;

        //   en rdy rd  rpc          ren addr          vld pc        instr
        add(1, 1, 0, 64'h0,        1, 64'h0,        0, 64'h0,    32'h0);   // 0
        add(1, 1, 0, 64'h0,        1, 64'h4,        0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h8,        1, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'hC,        1, 64'h4,    32'h1);
        add(1, 1, 0, 64'h0,        1, 64'h10,       1, 64'h8,    32'h2);
        add(1, 0, 0, 64'h0,        1, 64'h14,       1, 64'hC,    32'h3);   // 5: stall
        add(1, 0, 0, 64'h0,        1, 64'h18,       1, 64'hC,    32'h3);
        add(1, 0, 0, 64'h0,        0, 64'h1C,       1, 64'hC,    32'h3);   // credit exhausted
        add(1, 0, 0, 64'h0,        0, 64'h1C,       1, 64'hC,    32'h3);
        add(1, 1, 0, 64'h0,        0, 64'h1C,       1, 64'hC,    32'h3);
        add(1, 1, 0, 64'h0,        1, 64'h1C,       1, 64'h10,   32'h4);   // 10
        add(1, 1, 0, 64'h0,        1, 64'h20,       1, 64'h14,   32'h5);
        add(1, 1, 0, 64'h0,        1, 64'h24,       1, 64'h18,   32'h6);
        add(1, 0, 0, 64'h0,        1, 64'h28,       1, 64'h1C,   32'h7);
        add(1, 0, 1, 64'h100,      0, 64'h2C,       1, 64'h1C,   32'h7);   // 14: redirect, 3 queued + 1 in flight
        add(1, 1, 0, 64'h0,        1, 64'h100,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h104,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h108,      1, 64'h100,  32'h40);
        add(1, 1, 1, 64'h203,      0, 64'h10C,      1, 64'h104,  32'h41);  // 18: unaligned target
        add(1, 1, 0, 64'h0,        1, 64'h200,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h204,      0, 64'h0,    32'h0);   // 20
        add(1, 1, 0, 64'h0,        1, 64'h208,      1, 64'h200,  32'h80);
        add(1, 1, 1, TOP4,         0, 64'h20C,      1, 64'h204,  32'h81);  // 22: redirect to top of space
        add(1, 1, 0, 64'h0,        1, TOP4,         0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h0,        0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h4,        1, TOP4,     32'hFFFF_FFFF);
        add(1, 1, 0, 64'h0,        1, 64'h8,        1, 64'h0,    32'h0);
        add(1, 1, 1, 64'h300,      0, 64'hC,        1, 64'h4,    32'h1);   // 27: back-to-back redirects
        add(1, 1, 1, 64'h400,      0, 64'h300,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h400,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h404,      0, 64'h0,    32'h0);   // 30
        add(1, 1, 0, 64'h0,        1, 64'h408,      1, 64'h400,  32'h100);
        add(0, 1, 0, 64'h0,        0, 64'h40C,      1, 64'h404,  32'h101); // 32: enable dropped
        add(0, 1, 0, 64'h0,        0, 64'h40C,      1, 64'h408,  32'h102);
        add(0, 1, 0, 64'h0,        0, 64'h40C,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h40C,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h410,      0, 64'h0,    32'h0);
        add(1, 1, 0, 64'h0,        1, 64'h414,      1, 64'h40C,  32'h103);

        // Reset state, with enable already high to show issue is held off.
        repeat (2) @(negedge clk);
        enable = 1'b1;
        #1;
        check_reset_outputs(-1);
        @(negedge clk);
        arst = 1'b0; enable = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            enable = vecs[i].en; out_ready = vecs[i].rdy;
            redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
            #1;
            check("imem_ren",  i, 64'(imem_ren),  64'(vecs[i].exp_ren));
            check("imem_addr", i, imem_addr,      vecs[i].exp_addr);
            check("out_valid", i, 64'(out_valid), 64'(vecs[i].exp_vld));
            if (vecs[i].exp_vld) begin
                check("out_pc",    i, out_pc,         vecs[i].exp_head.pc);
                check("out_instr", i, 64'(out_instr), 64'(vecs[i].exp_head.instr));
            end
        end

        // Reset while the queue holds data.
        @(negedge clk);
        redirect = 1'b0; enable = 1'b1; out_ready = 1'b0; arst = 1'b1;
        #1;
        check_reset_outputs(100);

        // Fill from empty with a stalled consumer: exactly DEPTH reads.
        @(negedge clk);
        arst = 1'b0;
        ren_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (k == 0) check("fill_first_addr", 200, imem_addr, 64'h0);
            if (imem_ren) ren_cnt++;
            @(negedge clk);
        end
        check("fill_issue_count", 201, 64'(ren_cnt), 64'd4);
        check("fill_ren_held", 202, 64'(imem_ren), 64'h0);

        // Drain in order; issue resumes once a slot frees.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_valid", 300 + k, 64'(out_valid), 64'h1);
            check("drain_pc",    300 + k, out_pc,         64'(4 * k));
            check("drain_instr", 300 + k, 64'(out_instr), 64'(k));
            if (k == 0) check("drain_ren0", 300, 64'(imem_ren), 64'h0);
            if (k == 1) begin
                check("drain_ren1",  301, 64'(imem_ren), 64'h1);
                check("drain_addr1", 301, imem_addr,     64'h10);
            end
            @(negedge clk);
        end

        // Refill, then assert reset asynchronously in mid-cycle.
        out_ready = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("full_valid", 400, 64'(out_valid), 64'h1);
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check_reset_outputs(401);

        // Restart from RESET_PC.
        @(negedge clk);
        arst = 1'b0; out_ready = 1'b1;
        #1;
        check("restart_ren",  500, 64'(imem_ren), 64'h1);
        check("restart_addr", 500, imem_addr,     64'h0);
        @(negedge clk);
        #1;
        check("restart_valid1", 501, 64'(out_valid), 64'h0);
        check("restart_addr1",  501, imem_addr,      64'h4);
        @(negedge clk);
        #1;
        check("restart_valid2", 502, 64'(out_valid), 64'h1);
        check("restart_pc2",    502, out_pc,         64'h0);
        check("restart_instr2", 502, 64'(out_instr), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end with a prefetch queue; successor to the current single-register PC.
- Owns the fetch PC, issues sequential reads to the synchronous-read instruction memory, and buffers returned words with their PCs.
- Hands instructions to decode via a valid/ready handshake.
- Supports redirect (taken branch/jump) with queue flush and in-flight kill, so later pipelined cores can stall and redirect freely.

Parameters:
- DATA_W, 64: PC / address width in bits.
- INSTR_W, 32: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0: fetch address after reset.

Ports:
- clk  in  1: main clock; all state on rising edge.
- arst  in  1: asynchronous reset, active-high.
- enable  in  1: permits new memory requests.
- imem_addr  out  DATA_W: byte address to instruction memory.
- imem_ren  out  1: read request; data returns on imem_rdata exactly one cycle later.
- imem_rdata  in  INSTR_W: instruction memory read data.
- redirect  in  1: taken branch/jump this cycle.
- redirect_pc  in  DATA_W: redirect target.
- out_valid  out  1: head entry valid.
- out_ready  in  1: consumer accepts head.
- out_instr  out  INSTR_W: head instruction.
- out_pc  out  DATA_W: PC of head instruction.

Behaviour:
- Reset (async assert):
  - fetch_pc = RESET_PC; queue count = 0; in-flight flag = 0; storage cleared.
  - Outputs: out_valid=0, out_instr=0, out_pc=0, imem_ren=0, imem_addr=RESET_PC.
  - If reset asserts mid-operation, all queued and in-flight data is discarded.
- Issue rule:
  - imem_ren=1 when enable && !redirect && (count + inflight + pushes_pending) < DEPTH. In practice: count + inflight < DEPTH, with pop credit ignored (conservative).
  - imem_addr = fetch_pc.
  - On issue: fetch_pc += 4, wrapping modulo 2^DATA_W. inflight <= 1 and the issued PC is tagged.
- Return: the cycle after an issue, imem_rdata plus the tagged PC is pushed at the queue tail, unless killed.
- Pop: out_valid && out_ready removes the head. Push and pop in the same cycle leaves count unchanged. A pop while empty is ignored.
- No bypass: a returned word is visible on out_valid the cycle after its return.
- Latency: issue at cycle N, return at N+1, out_valid at N+2. Sustained throughput is 1 instruction/cycle with a continuously ready consumer.
- Full: the credit rule guarantees no push ever finds the queue full. No overflow path exists; the verifier asserts this.
- enable low: no new issues. An in-flight return still pushes, and the queue still drains.
- Redirect (highest priority):
  - Cycle r: queue flushed (count=0, out_valid drops next cycle), in-flight return at r+1 discarded, any pop at r discarded.
  - fetch_pc <= {redirect_pc[DATA_W-1:2], 2'b00}; imem_ren=0 in cycle r.
  - Issue of the target occurs at r+1, and the target is valid at r+3.
- Back-to-back redirects: the last one wins; each kills the previous target's in-flight return.
- Output fields when out_valid=0 are don't-care, except the reset values above.

Decomposition:
- Package fetch_pkg: PC_STEP=4, PC_ALIGN_BITS=2, INSTR_NOP=32'h00000013, and the queue entry struct {pc, instr}.
- Sub-module fetch_queue: synchronous FIFO, parameters DEPTH and entry width, with push, pop, flush, count, and head output.
- The top level holds the fetch PC, the in-flight tracker and the credit logic.

Test Plan:
- Reset release, enable=1, out_ready=1, memory returns addr/4 → out_pc 0,4,8,… with out_instr 0,1,2,…; first out_valid 2 cycles after the first imem_ren; then one instruction per cycle.
- out_ready=0 with DEPTH=4 → exactly 4 requests issued, then imem_ren=0; count holds at 4. Raise ready → 4 pops in order with no duplicates or gaps, and issue resumes.
- Redirect to 0x100 while the queue holds 3 entries and one read is in flight → out_valid=0 the next cycle; the stale return is dropped; imem_addr=0x100 at r+1; out_pc=0x100 valid at r+3.
- redirect_pc=0x203 → fetch from 0x200. Redirect to 2^64-4 → sequence 0xFFFF…FFFC, then 0x0.
- enable dropped while 1 read is in flight → that word is still delivered; no further imem_ren until enable returns.
- arst asserted mid-stream with a full queue → outputs immediately 0; after release, fetch restarts at RESET_PC.
